mode_select_ctrl: RTL and testbench

- Input-side controller for the mode-select menu screen. It reads the raw player buttons, then synchronises and debounces them.
- It moves a cursor between the two menu items, SCORE and TIME, and latches the chosen game mode on confirm.
- It drives the cursor position and blink signals consumed by the menu renderer.
- It drives in_menu and a one-cycle start pulse consumed by the game core. It returns to the menu when the game core signals game over.

---
 rtl/mode_select_ctrl_if.sv | 30 +++
 rtl/mode_select_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mode_select_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mode_select_ctrl_if.sv
// ============================================================================
// mode_select_ctrl_if : button/game-core/renderer bundle for mode_select_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface mode_select_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_confirm;
   logic       game_over;
   logic       in_menu;
   logic       cursor_sel;
   logic [9:0] cursor_y_ofs;
   logic       cursor_visible;
   logic       mode;
   logic       start_pulse;

   modport master (
      output btn_up, btn_down, btn_confirm, game_over,
      input  in_menu, cursor_sel, cursor_y_ofs, cursor_visible, mode, start_pulse
   );

   modport slave (
      input  btn_up, btn_down, btn_confirm, game_over,
      output in_menu, cursor_sel, cursor_y_ofs, cursor_visible, mode, start_pulse
   );
endinterface

`default_nettype wire

// File: rtl/mode_select_ctrl.sv
// ============================================================================
// mode_select_ctrl : debounced menu cursor, blink and game-mode latch
// Rev 1.0
// ============================================================================
`default_nettype none

module mode_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_CYCLES    = 12500000,
   parameter int SCORE_Y_OFS     = 130,
   parameter int TIME_Y_OFS      = 210
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   mode_select_ctrl_if.slave bus
);

   localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_BL_W-1:0] c_BL_LAST = c_BL_W'(BLINK_CYCLES - 1);
   localparam logic [9:0] c_SCORE_OFS = 10'(SCORE_Y_OFS);
   localparam logic [9:0] c_TIME_OFS  = 10'(TIME_Y_OFS);

   localparam logic [1:0] c_ST_MENU  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_PLAY  = 2'd2;

   // bit 0 = up, bit 1 = down, bit 2 = confirm
   logic [2:0] w_raw;
   logic [2:0] w_press;

   assign w_raw = {bus.btn_confirm, bus.btn_down, bus.btn_up};

   generate
      for (genvar i = 0; i < 3; i++) begin : g_btn
         logic              sync1_q;
         logic              sync2_q;
         logic              db_q;
         logic              db_prev_q;
         logic              press_q;
         logic [c_DB_W-1:0] cnt_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_q   <= 1'b0;
               sync2_q   <= 1'b0;
               db_q      <= 1'b0;
               db_prev_q <= 1'b0;
               press_q   <= 1'b0;
               cnt_q     <= '0;
            end else begin
               sync1_q <= w_raw[i];
               sync2_q <= sync1_q;
               if (sync2_q == db_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == c_DB_LAST) begin
                  db_q  <= sync2_q;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
               db_prev_q <= db_q;
               press_q   <= db_q & ~db_prev_q;
            end
         end

         assign w_press[i] = press_q;
      end
   endgenerate

   logic w_up_p;
   logic w_down_p;
   logic w_conf_p;

   assign w_up_p   = w_press[0];
   assign w_down_p = w_press[1];
   assign w_conf_p = w_press[2];

   logic [1:0]        state_q, state_d;
   logic              cursor_sel_q, cursor_sel_d;
   logic              mode_q, mode_d;
   logic              in_menu_q, in_menu_d;
   logic              start_pulse_q, start_pulse_d;
   logic [9:0]        y_ofs_q, y_ofs_d;
   logic [c_BL_W-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic              w_move;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_ST_MENU;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_MENU:  if (w_conf_p) state_d = c_ST_START;
         c_ST_START: state_d = c_ST_PLAY;
         c_ST_PLAY:  if (bus.game_over) state_d = c_ST_MENU;
         default:    state_d = c_ST_MENU;
      endcase
   end

   always_comb begin
      cursor_sel_d  = cursor_sel_q;
      mode_d        = mode_q;
      w_move        = 1'b0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;

      // confirm wins over a simultaneous direction press
      if (state_q == c_ST_MENU) begin
         if (w_conf_p) begin
            mode_d = cursor_sel_q;
         end else if (w_up_p ^ w_down_p) begin
            cursor_sel_d = ~cursor_sel_q;
            w_move       = 1'b1;
         end
      end

      in_menu_d     = (state_d == c_ST_MENU);
      start_pulse_d = (state_d == c_ST_START);
      y_ofs_d       = cursor_sel_d ? c_TIME_OFS : c_SCORE_OFS;

      // phase 0 means visible, so the reset value of every blink flop is 0
      if ((state_q == c_ST_MENU) && !w_move) begin
         if (blink_cnt_q == c_BL_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cursor_sel_q  <= 1'b0;
         mode_q        <= 1'b0;
         in_menu_q     <= 1'b1;
         start_pulse_q <= 1'b0;
         y_ofs_q       <= c_SCORE_OFS;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         cursor_sel_q  <= cursor_sel_d;
         mode_q        <= mode_d;
         in_menu_q     <= in_menu_d;
         start_pulse_q <= start_pulse_d;
         y_ofs_q       <= y_ofs_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign bus.in_menu        = in_menu_q;
   assign bus.cursor_sel     = cursor_sel_q;
   assign bus.cursor_y_ofs   = y_ofs_q;
   assign bus.cursor_visible = ~blink_phase_q;
   assign bus.mode           = mode_q;
   assign bus.start_pulse    = start_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_mode_select_ctrl.sv
// ============================================================================
// tb_mode_select_ctrl : directed self-checking bench for mode_select_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mode_select_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mode_select_ctrl_if u_if ();

   mode_select_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .BLINK_CYCLES    (5),
      .SCORE_Y_OFS     (130),
      .TIME_Y_OFS      (210)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic btns(input logic up, input logic dn, input logic cf);
      u_if.btn_up      = up;
      u_if.btn_down    = dn;
      u_if.btn_confirm = cf;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      btns(1'b0, 1'b0, 1'b0);
      u_if.game_over = 1'b0;
      tick(2);

      // 1: reset state
      chk("rst_in_menu", u_if.in_menu, 1);
      chk("rst_cursor_sel", u_if.cursor_sel, 0);
      chk("rst_y_ofs", u_if.cursor_y_ofs, 130);
      chk("rst_mode", u_if.mode, 0);
      chk("rst_start", u_if.start_pulse, 0);
      chk("rst_visible", u_if.cursor_visible, 1);
      rst_n = 1'b1;
      tick(2);

      // 2: a 3-cycle glitch is rejected
      btns(1'b0, 1'b1, 1'b0);
      tick(3);
      btns(1'b0, 1'b0, 1'b0);
      tick(15);
      chk("glitch_cursor", u_if.cursor_sel, 0);

      // 2: held press toggles exactly 8 clocks after first sampled high
      btns(1'b0, 1'b1, 1'b0);
      tick(7);
      chk("lat7_cursor", u_if.cursor_sel, 0);
      tick(1);
      chk("lat8_cursor", u_if.cursor_sel, 1);
      chk("lat8_y_ofs", u_if.cursor_y_ofs, 210);
      tick(12);
      chk("hold_one_toggle", u_if.cursor_sel, 1);
      btns(1'b0, 1'b0, 1'b0);
      tick(10);
      chk("release_no_toggle", u_if.cursor_sel, 1);

      // 3: wrap both ways, simultaneous up+down is a no-op
      btns(1'b0, 1'b1, 1'b0);
      tick(8);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);
      chk("down_wrap_cursor", u_if.cursor_sel, 0);
      chk("down_wrap_y_ofs", u_if.cursor_y_ofs, 130);
      btns(1'b1, 1'b0, 1'b0);
      tick(8);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);
      chk("up_wrap_cursor", u_if.cursor_sel, 1);
      chk("up_wrap_y_ofs", u_if.cursor_y_ofs, 210);
      btns(1'b1, 1'b1, 1'b0);
      tick(8);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);
      chk("updown_cursor", u_if.cursor_sel, 1);

      // 4: confirm with up; confirm wins, cursor holds
      btns(1'b1, 1'b0, 1'b1);
      tick(7);
      chk("conf7_in_menu", u_if.in_menu, 1);
      chk("conf7_start", u_if.start_pulse, 0);
      tick(1);
      chk("conf8_start", u_if.start_pulse, 1);
      chk("conf8_in_menu", u_if.in_menu, 0);
      chk("conf8_mode", u_if.mode, 1);
      chk("conf8_cursor", u_if.cursor_sel, 1);
      tick(1);
      chk("conf9_start", u_if.start_pulse, 0);
      chk("conf9_in_menu", u_if.in_menu, 0);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);

      // 5: PLAY ignores buttons
      btns(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("play_start", u_if.start_pulse, 0);
         chk("play_in_menu", u_if.in_menu, 0);
      end
      btns(1'b0, 1'b0, 1'b0);
      tick(10);
      chk("play_cursor", u_if.cursor_sel, 1);
      chk("play_mode", u_if.mode, 1);
      chk("play_visible", u_if.cursor_visible, 1);

      // 5: game_over returns to menu, selection retained
      u_if.game_over = 1'b1;
      tick(1);
      u_if.game_over = 1'b0;
      chk("go_in_menu", u_if.in_menu, 1);
      chk("go_cursor", u_if.cursor_sel, 1);
      chk("go_start", u_if.start_pulse, 0);
      chk("go_mode", u_if.mode, 1);

      // 6: blink every 5 clocks from menu entry
      chk("blink_g0", u_if.cursor_visible, 1);
      tick(4);
      chk("blink_g4", u_if.cursor_visible, 1);
      tick(1);
      chk("blink_g5", u_if.cursor_visible, 0);
      tick(5);
      chk("blink_g10", u_if.cursor_visible, 1);

      // 6: a move while blinked off forces visible and restarts the count
      btns(1'b0, 1'b1, 1'b0);
      tick(7);
      chk("blink_pre_move", u_if.cursor_visible, 0);
      chk("blink_pre_cursor", u_if.cursor_sel, 1);
      tick(1);
      chk("blink_move_cursor", u_if.cursor_sel, 0);
      chk("blink_move_vis", u_if.cursor_visible, 1);
      btns(1'b0, 1'b0, 1'b0);
      tick(4);
      chk("blink_restart4", u_if.cursor_visible, 1);
      tick(1);
      chk("blink_restart5", u_if.cursor_visible, 0);
      tick(4);

      // enter PLAY with mode=1 again
      btns(1'b1, 1'b0, 1'b0);
      tick(8);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);
      chk("replay_cursor", u_if.cursor_sel, 1);
      btns(1'b0, 1'b0, 1'b1);
      tick(8);
      btns(1'b0, 1'b0, 1'b0);
      tick(8);
      chk("replay_in_menu", u_if.in_menu, 0);
      chk("replay_mode", u_if.mode, 1);

      // 6: asynchronous reset mid-PLAY, checked before any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_menu", u_if.in_menu, 1);
      chk("arst_cursor", u_if.cursor_sel, 0);
      chk("arst_y_ofs", u_if.cursor_y_ofs, 130);
      chk("arst_mode", u_if.mode, 0);
      chk("arst_start", u_if.start_pulse, 0);
      chk("arst_visible", u_if.cursor_visible, 1);
      tick(2);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         chk("post_rst_start", u_if.start_pulse, 0);
         chk("post_rst_in_menu", u_if.in_menu, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
